// File: rtl/dmem_rr_arbiter.sv
// dmem_rr_arbiter: round-robin arbiter sharing one single-port data memory
// between NCORES cores. Each granted request becomes exactly one memory
// access (IDLE -> ACCESS -> [WAIT x READ_LAT] -> RESP) and is closed by a
// one-cycle ack to the requester. All outputs come straight from flops.

module dmem_rr_arbiter #(
    parameter int WIDTH    = 16,
    parameter int NCORES   = 8,
    parameter int READ_LAT = 1,
    localparam int IDW     = (NCORES > 1) ? $clog2(NCORES) : 1
) (
    input  logic                      Clk,
    input  logic                      Rst,
    input  logic [NCORES-1:0]         req_rd,
    input  logic [NCORES-1:0]         req_wr,
    input  logic [NCORES*WIDTH-1:0]   req_addr,
    input  logic [NCORES*WIDTH-1:0]   req_wdata,
    output logic [NCORES-1:0]         ack,
    output logic [WIDTH-1:0]          rdata,
    output logic [WIDTH-1:0]          mem_addr,
    output logic [WIDTH-1:0]          mem_wdata,
    output logic                      mem_wEn,
    output logic                      mem_rEn,
    input  logic [WIDTH-1:0]          mem_rdata,
    output logic                      busy,
    output logic [IDW-1:0]            grant_id
);

    localparam int CW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam logic [IDW:0]   NC_L     = (IDW+1)'(NCORES);
    localparam logic [IDW-1:0] LAST_ID  = IDW'(NCORES - 1);
    localparam logic [CW-1:0]  WAIT_TOP = CW'(READ_LAT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    // Registered state and outputs
    state_t              state_r;
    logic [IDW-1:0]      ptr_r;
    logic [IDW-1:0]      grant_r;
    logic                op_wr_r;
    logic [CW-1:0]       wait_cnt_r;
    logic [WIDTH-1:0]    addr_r;
    logic [WIDTH-1:0]    wdata_r;
    logic                wen_r;
    logic                ren_r;
    logic [NCORES-1:0]   ack_r;
    logic [WIDTH-1:0]    rdata_r;
    logic                busy_r;

    // Next-cycle values
    state_t              state_next_s;
    logic [IDW-1:0]      ptr_s;
    logic [IDW-1:0]      grant_s;
    logic                op_wr_s;
    logic [CW-1:0]       wait_cnt_s;
    logic [WIDTH-1:0]    addr_s;
    logic [WIDTH-1:0]    wdata_s;
    logic                wen_s;
    logic                ren_s;
    logic [NCORES-1:0]   ack_s;
    logic [WIDTH-1:0]    rdata_s;
    logic                busy_s;

    // Arbitration scan results
    logic [NCORES-1:0]   pending_s;
    logic                found_s;
    logic [IDW-1:0]      pick_s;
    logic [IDW:0]        idx_s;
    logic [WIDTH-1:0]    sel_addr_s;
    logic [WIDTH-1:0]    sel_wdata_s;
    logic                sel_wr_s;

    // One-hot decode of a core index, used to build the ack vector
    function automatic logic [NCORES-1:0] core_onehot(input logic [IDW-1:0] id);
        logic [NCORES-1:0] vec;
        vec     = '0;
        vec[id] = 1'b1;
        return vec;
    endfunction

    // Round-robin scan: first pending core starting at ptr, wrapping at NCORES
    always_comb begin
        pending_s = req_rd | req_wr;
        found_s   = 1'b0;
        pick_s    = '0;
        idx_s     = '0;
        for (int k = 0; k < NCORES; k++) begin
            idx_s = {1'b0, ptr_r} + (IDW+1)'(k);
            if (idx_s >= NC_L) begin
                idx_s = idx_s - NC_L;
            end else begin
                idx_s = idx_s;
            end
            if (!found_s && pending_s[idx_s[IDW-1:0]]) begin
                found_s = 1'b1;
                pick_s  = idx_s[IDW-1:0];
            end else begin
                found_s = found_s;
            end
        end
    end

    // Operand mux for the winning core; a simultaneous write beats a read
    always_comb begin
        sel_addr_s  = req_addr[pick_s*WIDTH +: WIDTH];
        sel_wdata_s = req_wdata[pick_s*WIDTH +: WIDTH];
        sel_wr_s    = req_wr[pick_s];
    end

    // State register with synchronous reset
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (found_s) begin
                    state_next_s = ACCESS;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ACCESS: begin
                if (op_wr_r) begin
                    state_next_s = RESP;
                end else begin
                    state_next_s = WAIT;
                end
            end
            WAIT: begin
                if (wait_cnt_r == '0) begin
                    state_next_s = RESP;
                end else begin
                    state_next_s = WAIT;
                end
            end
            RESP: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Output decode: values the output flops take on the next edge, so each
    // strobe/ack lines up with the state it belongs to
    always_comb begin
        ptr_s      = ptr_r;
        grant_s    = grant_r;
        op_wr_s    = op_wr_r;
        wait_cnt_s = wait_cnt_r;
        addr_s     = addr_r;
        wdata_s    = wdata_r;
        wen_s      = 1'b0;
        ren_s      = 1'b0;
        ack_s      = '0;
        rdata_s    = rdata_r;
        busy_s     = (state_next_s != IDLE);
        case (state_r)
            IDLE: begin
                if (found_s) begin
                    grant_s = pick_s;
                    addr_s  = sel_addr_s;
                    wdata_s = sel_wdata_s;
                    op_wr_s = sel_wr_s;
                    wen_s   = sel_wr_s;
                    ren_s   = !sel_wr_s;
                end else begin
                    grant_s = grant_r;
                end
            end
            ACCESS: begin
                wait_cnt_s = WAIT_TOP;
                if (op_wr_r) begin
                    ack_s = core_onehot(grant_r);
                end else begin
                    ack_s = '0;
                end
            end
            WAIT: begin
                if (wait_cnt_r == '0) begin
                    rdata_s = mem_rdata;
                    ack_s   = core_onehot(grant_r);
                end else begin
                    wait_cnt_s = wait_cnt_r - 1'b1;
                end
            end
            RESP: begin
                if (grant_r == LAST_ID) begin
                    ptr_s = '0;
                end else begin
                    ptr_s = grant_r + 1'b1;
                end
            end
            default: begin
                ptr_s = ptr_r;
            end
        endcase
    end

    // Output and datapath registers; reset drops any in-flight transaction
    always_ff @(posedge Clk) begin
        if (Rst) begin
            ptr_r      <= '0;
            grant_r    <= '0;
            op_wr_r    <= 1'b0;
            wait_cnt_r <= '0;
            addr_r     <= '0;
            wdata_r    <= '0;
            wen_r      <= 1'b0;
            ren_r      <= 1'b0;
            ack_r      <= '0;
            rdata_r    <= '0;
            busy_r     <= 1'b0;
        end else begin
            ptr_r      <= ptr_s;
            grant_r    <= grant_s;
            op_wr_r    <= op_wr_s;
            wait_cnt_r <= wait_cnt_s;
            addr_r     <= addr_s;
            wdata_r    <= wdata_s;
            wen_r      <= wen_s;
            ren_r      <= ren_s;
            ack_r      <= ack_s;
            rdata_r    <= rdata_s;
            busy_r     <= busy_s;
        end
    end

    assign ack       = ack_r;
    assign rdata     = rdata_r;
    assign mem_addr  = addr_r;
    assign mem_wdata = wdata_r;
    assign mem_wEn   = wen_r;
    assign mem_rEn   = ren_r;
    assign busy      = busy_r;
    assign grant_id  = grant_r;

endmodule

// File: tb/tb_dmem_rr_arbiter.sv
// Directed bench for dmem_rr_arbiter with a scoreboard of expected acks
// and a small behavioural memory (read latency 1).

module tb_dmem_rr_arbiter;

    localparam int WIDTH    = 16;
    localparam int NCORES   = 8;
    localparam int READ_LAT = 1;
    localparam int IDW      = 3;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NCORES-1:0]       req_rd;
    logic [NCORES-1:0]       req_wr;
    logic [NCORES*WIDTH-1:0] req_addr;
    logic [NCORES*WIDTH-1:0] req_wdata;
    logic [NCORES-1:0]       ack;
    logic [WIDTH-1:0]        rdata;
    logic [WIDTH-1:0]        mem_addr;
    logic [WIDTH-1:0]        mem_wdata;
    logic                    mem_wEn;
    logic                    mem_rEn;
    logic [WIDTH-1:0]        mem_rdata;
    logic                    busy;
    logic [IDW-1:0]          grant_id;

    typedef struct {
        int         id;
        bit         is_rd;
        logic [15:0] data;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int          wen_cnt = 0;
    int          ren_cnt = 0;
    logic [15:0] mem_m [logic [15:0]];

    dmem_rr_arbiter #(.WIDTH(WIDTH), .NCORES(NCORES), .READ_LAT(READ_LAT)) dut (
        .Clk(clk), .Rst(rst),
        .req_rd(req_rd), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .ack(ack), .rdata(rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wEn(mem_wEn), .mem_rEn(mem_rEn),
        .mem_rdata(mem_rdata),
        .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    function automatic void chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endfunction

    function automatic int onehot_idx(logic [NCORES-1:0] v);
        int r;
        r = -1;
        for (int j = 0; j < NCORES; j++) if (v[j]) r = j;
        return r;
    endfunction

    // Memory model: write on wEn, read data valid one cycle after rEn
    always @(posedge clk) begin
        if (mem_wEn === 1'b1) mem_m[mem_addr] = mem_wdata;
        if (mem_rEn === 1'b1) begin
            if (mem_m.exists(mem_addr)) mem_rdata <= mem_m[mem_addr];
            else                        mem_rdata <= mem_addr ^ 16'hC3C3;
        end
    end

    // Monitor: strobe exclusivity, ack one-hot, scoreboard compare
    always @(negedge clk) begin
        if (mem_wEn === 1'b1) wen_cnt++;
        if (mem_rEn === 1'b1) ren_cnt++;
        chk("strobe_excl", {31'd0, mem_wEn & mem_rEn}, 32'd0);
        if (ack != 8'd0) begin
            chk("ack_onehot", {24'd0, ack & 8'(ack - 8'd1)}, 32'd0);
            if (sb_q.size() == 0) begin
                chk("spurious_ack", {24'd0, ack}, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                chk("sb_ack_id", {24'd0, ack}, 32'd1 << mon_e.id);
                if (mon_e.is_rd) chk("sb_rdata", {16'd0, rdata}, {16'd0, mon_e.data});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_core(int i, logic [15:0] a, logic [15:0] d);
        req_addr[i*WIDTH +: WIDTH]  = a;
        req_wdata[i*WIDTH +: WIDTH] = d;
    endtask

    // Requester model: drop the request of each acked core, stop after n acks
    task automatic run_until(string tag, int n, int budget);
        int got;
        int cyc;
        got = 0;
        cyc = 0;
        while (got < n && cyc < budget) begin
            tick();
            cyc++;
            if (ack != 8'd0) begin
                got++;
                req_wr = req_wr & ~ack;
                req_rd = req_rd & ~ack;
            end
        end
        chk(tag, got, n);
    endtask

    initial begin
        int          acks;
        int          cyc;
        int          last;
        int          g[10];
        logic [7:0]  dropped;
        logic [7:0]  mask;

        rst = 1'b1; req_rd = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
        mem_m[16'h007F] = 16'hBEEF;
        tick(); tick();
        chk("rst_busy", busy, 0);     chk("rst_ack", ack, 0);
        chk("rst_wen", mem_wEn, 0);   chk("rst_ren", mem_rEn, 0);
        chk("rst_addr", mem_addr, 0); chk("rst_wdata", mem_wdata, 0);
        chk("rst_rdata", rdata, 0);   chk("rst_gid", grant_id, 0);
        rst = 1'b0;

        // Single write by core 2
        req_wr[2] = 1'b1; set_core(2, 16'h00BF, 16'h1234);
        sb_q.push_back('{2, 1'b0, 16'h0});
        chk("t1_busy_T", busy, 0);
        tick();
        chk("t1_wen", mem_wEn, 1);    chk("t1_ren", mem_rEn, 0);
        chk("t1_addr", mem_addr, 32'h00BF); chk("t1_wdata", mem_wdata, 32'h1234);
        chk("t1_busy1", busy, 1);     chk("t1_gid", grant_id, 2); chk("t1_noack", ack, 0);
        tick();
        chk("t1_ack", ack, 32'h04);   chk("t1_busy2", busy, 1); chk("t1_wen_off", mem_wEn, 0);
        req_wr[2] = 1'b0;
        tick();
        chk("t1_idle", busy, 0);      chk("t1_ack_off", ack, 0);

        // Single read by core 0
        req_rd[0] = 1'b1; set_core(0, 16'h007F, 16'h0000);
        sb_q.push_back('{0, 1'b1, 16'hBEEF});
        tick();
        chk("t2_ren", mem_rEn, 1);    chk("t2_wen", mem_wEn, 0); chk("t2_addr1", mem_addr, 32'h007F);
        tick();
        chk("t2_ren_off", mem_rEn, 0); chk("t2_addr2", mem_addr, 32'h007F);
        chk("t2_noack", ack, 0);      chk("t2_busy", busy, 1);
        tick();
        chk("t2_ack", ack, 32'h01);   chk("t2_rdata", rdata, 32'hBEEF);
        req_rd[0] = 1'b0;
        tick();
        chk("t2_idle", busy, 0);      chk("t2_rdata_hold", rdata, 32'hBEEF);

        // All cores writing continuously from reset
        rst = 1'b1; tick(); rst = 1'b0;
        chk("t3_rst_rdata", rdata, 0);
        for (int i = 0; i < NCORES; i++) set_core(i, 16'h0100 + 16'(i), 16'hA000 + 16'(i));
        for (int i = 0; i < 10; i++) sb_q.push_back('{i % NCORES, 1'b0, 16'h0});
        req_wr = 8'hFF; dropped = '0; acks = 0; cyc = 0; last = 0;
        while (acks < 10 && cyc < 200) begin
            tick();
            cyc++;
            if (ack != 8'd0) begin
                g[acks] = onehot_idx(ack);
                if (acks > 0) chk("t3_gap", cyc - last, 3);
                last = cyc;
                acks++;
            end
            req_wr  = (req_wr | dropped) & ~ack;
            dropped = ack;
            if (acks == 10) req_wr = '0;
        end
        chk("t3_count", acks, 10);
        for (int w = 0; w < 3; w++) begin
            mask = '0;
            for (int j = 0; j < 8; j++) if (g[w+j] >= 0) mask = mask | (8'd1 << g[w+j]);
            chk("t3_fair", mask, 32'hFF);
        end
        tick();
        chk("t3_idle", busy, 0);

        // Wrap: core 5 served -> ptr 6, then cores 1 and 7 pending
        req_wr[5] = 1'b1; sb_q.push_back('{5, 1'b0, 16'h0});
        run_until("t4_core5", 1, 20);
        req_wr[1] = 1'b1; req_wr[7] = 1'b1;
        sb_q.push_back('{7, 1'b0, 16'h0}); sb_q.push_back('{1, 1'b0, 16'h0});
        run_until("t4_wrap", 2, 20);
        req_wr[0] = 1'b1; req_wr[2] = 1'b1;
        sb_q.push_back('{2, 1'b0, 16'h0}); sb_q.push_back('{0, 1'b0, 16'h0});
        run_until("t4_ptr2", 2, 20);

        // Read and write together on one core: write wins
        tick();
        wen_cnt = 0; ren_cnt = 0;
        req_rd[4] = 1'b1; req_wr[4] = 1'b1; set_core(4, 16'h0044, 16'h4444);
        sb_q.push_back('{4, 1'b0, 16'h0});
        run_until("t5_ack", 1, 20);
        tick(); tick(); tick();
        chk("t5_wen_cnt", wen_cnt, 1);
        chk("t5_ren_cnt", ren_cnt, 0);
        chk("t5_memwr", mem_m.exists(16'h0044) ? {16'd0, mem_m[16'h0044]} : 32'hFFFF_FFFF, 32'h4444);

        // Reset during WAIT of a read by core 3
        req_rd[3] = 1'b1; set_core(3, 16'h0033, 16'h0000);
        tick();
        chk("t6_ren", mem_rEn, 1);
        tick();
        chk("t6_wait_busy", busy, 1);
        rst = 1'b1;
        tick();
        chk("t6_busy", busy, 0);      chk("t6_ack", ack, 0);
        chk("t6_wen", mem_wEn, 0);    chk("t6_ren_off", mem_rEn, 0);
        chk("t6_gid", grant_id, 0);   chk("t6_addr", mem_addr, 0);
        rst = 1'b0; req_rd[3] = 1'b0;
        req_wr[5] = 1'b1; req_wr[1] = 1'b1;
        sb_q.push_back('{1, 1'b0, 16'h0}); sb_q.push_back('{5, 1'b0, 16'h0});
        run_until("t6_after", 2, 20);

        tick(); tick(); tick();
        chk("sb_empty", sb_q.size(), 0);
        chk("final_idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_rr_arbiter.md
Name: dmem_rr_arbiter

Overview:
- Round-robin arbiter that shares the single-port data memory between NCORES cores.
- Each core presents a read or write request with address and data and holds it until it receives a one-cycle acknowledge.
- The arbiter serialises the requests into single memory accesses and returns read data to the requester.
- Sits between the core array and data_mem.

Parameters:
WIDTH, 16, data and address width in bits
NCORES, 8, number of requesting cores (2..16)
READ_LAT, 1, memory cycles from mem_rEn to valid mem_rdata (>=1)

Ports:
Clk  input  1  system clock
Rst  input  1  reset, synchronous, active-high
req_rd  input  NCORES  per-core read request, held until ack
req_wr  input  NCORES  per-core write request, held until ack
req_addr  input  NCORES*WIDTH  per-core address, core i at bits [i*WIDTH +: WIDTH]
req_wdata  input  NCORES*WIDTH  per-core write data, same packing
ack  output  NCORES  one-cycle done pulse per core (one-hot or zero)
rdata  output  WIDTH  read data; valid in the ack cycle of a read
mem_addr  output  WIDTH  memory address
mem_wdata  output  WIDTH  memory write data
mem_wEn  output  1  memory write strobe
mem_rEn  output  1  memory read strobe
mem_rdata  input  WIDTH  memory read data
busy  output  1  high whenever state != IDLE
grant_id  output  clog2(NCORES)  index of the core currently served

Behaviour:
- Reset, or Rst asserted in any state: state=IDLE, ptr=0, ack=0, mem_wEn=0, mem_rEn=0, rdata=0, mem_addr=0, mem_wdata=0, grant_id=0, busy=0. Any in-flight transaction is dropped with no ack.
- Core i is pending when req_rd[i] | req_wr[i].
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE:
  - Choose the first pending core scanning ptr, ptr+1, ... NCORES-1, 0, ... with wrap-around.
  - If one is found, register grant_id, mem_addr, mem_wdata and op, then go to ACCESS.
  - If none is pending, stay in IDLE.
  - Op: write if req_wr[i]; read otherwise. If both are set, the write wins and the read is ignored.
- ACCESS (1 cycle): assert mem_wEn (write) or mem_rEn (read). Next state is RESP for a write, WAIT for a read.
- WAIT:
  - Lasts exactly READ_LAT cycles.
  - mem_addr is held stable throughout.
  - On the last WAIT cycle, mem_rdata is captured into rdata.
  - Next state is RESP.
- RESP (1 cycle):
  - ack[grant_id]=1.
  - rdata keeps its captured value until the next read capture. It is not cleared.
  - ptr <= (grant_id+1) mod NCORES, then go to IDLE.
- Strobes: mem_wEn and mem_rEn are never high together and are high only in ACCESS.
- Latency from pending in IDLE cycle T:
  - write: wEn in T+1, ack in T+2.
  - read: rEn in T+1, ack in T+2+READ_LAT.
  - Maximum throughput is one write per 3 cycles.
- Requester rules:
  - Hold req and its addr/wdata stable until ack.
  - Drop req for the cycle after ack; the arbiter re-samples in that cycle.
  - A req still high then is treated as a new request.
- Request changes while the core is not granted are legal. Request changes while the core is granted are ignored, because the operands were latched in IDLE.
- Fairness: with all cores continuously pending, each core is served exactly once every NCORES grants.
- Ack goes to exactly one core per transaction; there are no spurious acks.
- grant_id is valid from ACCESS through RESP and keeps its value in IDLE.

Test Plan:
- Single write: core 2 req_wr, addr 0x00BF, data 0x1234 from IDLE -> mem_wEn=1 with addr 0x00BF, wdata 0x1234 one cycle later; ack=8'b0000_0100 two cycles after the request; busy high for 2 cycles.
- Single read, READ_LAT=1: memory model returns 0xBEEF for addr 0x007F; core 0 req_rd -> mem_rEn at T+1, ack[0] and rdata=0xBEEF at T+3, mem_addr stable over T+1..T+2.
- All 8 cores writing continuously from reset -> grant order 0,1,2,...,7,0; each ack exactly 3 cycles apart; no core granted twice in any 8 consecutive grants.
- Wrap: ptr=6 with cores 1 and 7 pending -> core 7 is served first, then core 1; ptr ends at 2.
- Same core asserts req_rd and req_wr together -> only mem_wEn pulses, no mem_rEn, one ack.
- Rst asserted during WAIT of a read by core 3 -> next cycle: IDLE, no ack[3], all strobes 0, ptr=0; a subsequent core 5 write completes normally with ack[5].
